// File: rtl/sram_stream_reader_pkg.sv
// Shared types and geometry for the sample-SRAM read sequencer.
package sram_stream_reader_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int SRAM_WORDS = 2048;
    localparam int BANK_AW    = 9;
    localparam int BANKS      = 4;
    localparam int IDX_W      = 11;
    localparam int CNT_W      = 12;
endpackage

// File: rtl/sram_reader_fifo.sv
// DEPTH-entry synchronous FIFO with flush; head entry is presented combinationally.
module sram_reader_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
endmodule

// File: rtl/sram_stream_reader.sv
// Burst reader over the four sample SRAM banks feeding a valid/ready stream.
// Optional running checksum of delivered words: define SRAM_READER_CHECKSUM_EN.
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [IDX_W-1:0]     start_addr_i,
    input  logic [CNT_W-1:0]     count_i,
    output logic [BANKS-1:0]     mem_renb_o,
    output logic [BANK_AW-1:0]   mem_raddr_o,
    input  logic [31:0]          mem0_data_i,
    input  logic [31:0]          mem1_data_i,
    input  logic [31:0]          mem2_data_i,
    input  logic [31:0]          mem3_data_i,
    output logic [31:0]          m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          checksum_o
);
    localparam int CW = $clog2(DEPTH + 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   addr;
    logic [CNT_W-1:0]   remaining;
    logic [BANK_AW-1:0] raddr_q;
    logic               inflight;
    logic [1:0]         inflight_bank;
    logic               done_q, done_nxt;
    logic               load, issue, pop, fifo_empty;
    logic [CW-1:0]      fifo_occ;
    logic [CW:0]        used;
    logic [31:0]        rd_data;

    assign pop  = !fifo_empty && m_ready_i;
    // Words already committed: buffered plus the one in the SRAM pipe, less any leaving now.
    assign used = {1'b0, fifo_occ} + (CW+1)'(inflight) - (CW+1)'(pop);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        load      = 1'b0;
        done_nxt  = 1'b0;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start_i) begin
                    if (count_i != '0) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
                RUN: begin
                    issue = (remaining != '0) && (used < (CW+1)'(DEPTH));
                    if (issue && remaining == CNT_W'(1)) state_nxt = DRAIN;
                end
                DRAIN: if (!inflight && fifo_occ == CW'(pop)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            raddr_q       <= '0;
            inflight      <= 1'b0;
            inflight_bank <= '0;
            done_q        <= 1'b0;
        end else begin
            state    <= state_nxt;
            done_q   <= done_nxt;
            inflight <= issue;
            if (load) begin
                addr      <= start_addr_i;
                remaining <= count_i;
            end else if (issue) begin
                addr          <= addr + 1'b1;
                remaining     <= remaining - 1'b1;
                raddr_q       <= addr[BANK_AW-1:0];
                inflight_bank <= addr[IDX_W-1 -: 2];
            end
        end
    end

    always_comb begin
        unique case (inflight_bank)
            2'd0:    rd_data = mem0_data_i;
            2'd1:    rd_data = mem1_data_i;
            2'd2:    rd_data = mem2_data_i;
            default: rd_data = mem3_data_i;
        endcase
    end

    sram_reader_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (abort_i),
        .push  (inflight),
        .wdata (rd_data),
        .pop   (pop),
        .rdata (m_data_o),
        .count (fifo_occ),
        .empty (fifo_empty)
    );

    assign mem_renb_o  = issue ? ~(4'b0001 << addr[IDX_W-1 -: 2]) : 4'hF;
    assign mem_raddr_o = issue ? addr[BANK_AW-1:0] : raddr_q;
    assign m_valid_o   = !fifo_empty;
    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;

`ifdef SRAM_READER_CHECKSUM_EN
    logic [31:0] csum;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)     csum <= '0;
        else if (abort_i) csum <= csum;
        else if (load)    csum <= '0;
        else if (pop)     csum <= csum + m_data_o;
    end
    assign checksum_o = csum;
`else
    assign checksum_o = '0;
`endif
endmodule
